// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state, mode and error encodings for the matrix calculator controller
package ctrl_pkg;
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INPUT    = 3'd1,
        S_GEN      = 3'd2,
        S_DISPLAY  = 3'd3,
        S_CALC_SEL = 3'd4,
        S_CALC_RUN = 3'd5,
        S_ERROR    = 3'd6
    } state_t;
    localparam logic [2:0] MODE_INPUT   = 3'd0;
    localparam logic [2:0] MODE_GEN     = 3'd1;
    localparam logic [2:0] MODE_DISPLAY = 3'd2;
    localparam logic [2:0] MODE_CALC    = 3'd3;
    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL  = 2'd1;
    localparam logic [1:0] ERR_WDOG     = 2'd2;
endpackage

// File: rtl/main_ctrl_fsm_if.sv
// main_ctrl_fsm_if: user inputs, sub-unit handshakes and status outputs of the controller
interface main_ctrl_fsm_if #(parameter int OP_W = 3);
    logic [2:0]      mode_select;
    logic [OP_W-1:0] op_select;
    logic            confirm_btn;
    logic            back_btn;
    logic            op_legal;
    logic            sub_done;
    logic            op_done;
    logic [2:0]      state_out;
    logic [OP_W-1:0] op_type;
    logic            input_en;
    logic            gen_en;
    logic            display_en;
    logic            calc_start;
    logic            busy;
    logic [1:0]      err_code;
    logic [3:0]      err_countdown;
    modport master (
        input  mode_select, op_select, confirm_btn, back_btn, op_legal, sub_done, op_done,
        output state_out, op_type, input_en, gen_en, display_en, calc_start, busy, err_code, err_countdown
    );
    modport slave (
        output mode_select, op_select, confirm_btn, back_btn, op_legal, sub_done, op_done,
        input  state_out, op_type, input_en, gen_en, display_en, calc_start, busy, err_code, err_countdown
    );
endinterface

// File: rtl/btn_edge.sv
// btn_edge: one-cycle press event on the rising edge of a debounced button level
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);
    logic btn_q;
    // remember last cycle's level so a held button yields a single event
    always_ff @(posedge clk) begin
        if (!rst_n) btn_q <= 1'b0;
        else        btn_q <= btn_i;
    end
    assign press_o = btn_i & ~btn_q;
endmodule

// File: rtl/main_ctrl_fsm.sv
// main_ctrl_fsm: top-level mode sequencer with op legality check, watchdog and timed error state
module main_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int OP_W         = 3,
    parameter int ERR_CYCLES   = 500_000_000,
    parameter int CALC_TIMEOUT = 1_000_000,
    parameter int CNT_W        = 32
) (
    input logic             clk,
    input logic             rst_n,
    main_ctrl_fsm_if.master bus
);
    localparam logic [CNT_W-1:0] ERR_LOAD = CNT_W'(ERR_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(CALC_TIMEOUT - 1);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OP_W-1:0]  op_type_q, op_type_d;
    logic [1:0]       err_q, err_d;
    logic             start_q, start_d;
    logic             conf_p, back_p;
    logic [3:0]       cd;
    btn_edge u_conf (.clk(clk), .rst_n(rst_n), .btn_i(bus.confirm_btn), .press_o(conf_p));
    btn_edge u_back (.clk(clk), .rst_n(rst_n), .btn_i(bus.back_btn),    .press_o(back_p));
    // state, shared run/error counter, latched op and error code
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_type_q <= '0;
            err_q     <= ERR_NONE;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_type_q <= op_type_d;
            err_q     <= err_d;
            start_q   <= start_d;
        end
    end
    // next-state: counter counts up in CALC_RUN and down in ERROR
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_type_d = op_type_q;
        err_d     = err_q;
        start_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (conf_p) begin
                    case (bus.mode_select)
                        MODE_INPUT:   state_d = S_INPUT;
                        MODE_GEN:     state_d = S_GEN;
                        MODE_DISPLAY: state_d = S_DISPLAY;
                        MODE_CALC:    state_d = S_CALC_SEL;
                        default:      state_d = S_IDLE;
                    endcase
                end
            end
            S_INPUT, S_GEN, S_DISPLAY: begin
                if (bus.sub_done || back_p) state_d = S_IDLE;
            end
            S_CALC_SEL: begin
                if (back_p) begin
                    state_d = S_IDLE;
                end else if (conf_p && bus.op_legal) begin
                    op_type_d = bus.op_select;
                    start_d   = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_CALC_RUN;
                end else if (conf_p) begin
                    err_d   = ERR_ILLEGAL;
                    cnt_d   = ERR_LOAD;
                    state_d = S_ERROR;
                end
            end
            S_CALC_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.op_done) begin
                    err_d   = ERR_NONE;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = ERR_WDOG;
                    cnt_d   = ERR_LOAD;
                    state_d = S_ERROR;
                end
            end
            S_ERROR: begin
                cnt_d = cnt_q - 1'b1;
                if (back_p || cnt_q == '0) begin
                    state_d = (!back_p && err_q == ERR_ILLEGAL) ? S_CALC_SEL : S_IDLE;
                    err_d   = ERR_NONE;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
    // ceil(cnt*10/ERR_CYCLES) as a count of tenths thresholds already exceeded
    always_comb begin
        cd = '0;
        for (int k = 0; k < 10; k++)
            cd = cd + ((64'(cnt_q) * 64'd10 > 64'(k) * 64'(ERR_CYCLES)) ? 4'd1 : 4'd0);
    end
    assign bus.state_out     = state_q;
    assign bus.op_type       = op_type_q;
    assign bus.input_en      = state_q == S_INPUT;
    assign bus.gen_en        = state_q == S_GEN;
    assign bus.display_en    = state_q == S_DISPLAY;
    assign bus.calc_start    = start_q;
    assign bus.busy          = state_q == S_CALC_RUN;
    assign bus.err_code      = err_q;
    assign bus.err_countdown = (state_q == S_ERROR) ? cd : 4'd0;
endmodule

// File: tb/tb_main_ctrl_fsm.sv
// tb_main_ctrl_fsm: directed stimulus with a cycle model and literal spot checks
module tb_main_ctrl_fsm;
    localparam int ERR = 10;
    localparam int TO  = 16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    main_ctrl_fsm_if #(.OP_W(3)) bus ();
    main_ctrl_fsm #(.OP_W(3), .ERR_CYCLES(ERR), .CALC_TIMEOUT(TO), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    // model state: flow position, latched op, error code, launch pulse, run cycles, error cycles left
    int m_st = 0, m_op = 0, m_err = 0, m_start = 0, m_run = 0, m_left = 0, m_pc = 0, m_pb = 0;
    always @(posedge clk) begin : model
        int st, op, er, run, left, launch;
        bit cp, bp;
        st = m_st; op = m_op; er = m_err; run = m_run; left = m_left; launch = 0;
        cp = bus.confirm_btn && m_pc == 0;
        bp = bus.back_btn && m_pb == 0;
        if (!rst_n) begin
            st = 0; op = 0; er = 0; run = 0; left = 0;
        end else begin
            case (st)
                0: if (cp && bus.mode_select < 4) st = int'(bus.mode_select) + 1;
                1, 2, 3: if (bus.sub_done || bp) st = 0;
                4: begin
                    if (bp) st = 0;
                    else if (cp && bus.op_legal) begin op = int'(bus.op_select); launch = 1; run = 0; st = 5; end
                    else if (cp) begin er = 1; left = ERR; st = 6; end
                end
                5: begin
                    run++;
                    if (bus.op_done) begin st = 0; er = 0; end
                    else if (run == TO) begin er = 2; left = ERR; st = 6; end
                end
                6: begin
                    left--;
                    if (bp || left == 0) begin st = (!bp && er == 1) ? 4 : 0; er = 0; end
                end
                default: st = 0;
            endcase
        end
        m_st <= st; m_op <= op; m_err <= er; m_run <= run; m_left <= left; m_start <= launch;
        m_pc <= rst_n ? int'(bus.confirm_btn) : 0;
        m_pb <= rst_n ? int'(bus.back_btn) : 0;
    end
    always @(negedge clk) begin
        if (chk_en) begin
            chk("state", 32'(bus.state_out), 32'(m_st));
            chk("op_type", 32'(bus.op_type), 32'(m_op));
            chk("input_en", 32'(bus.input_en), 32'(m_st == 1));
            chk("gen_en", 32'(bus.gen_en), 32'(m_st == 2));
            chk("display_en", 32'(bus.display_en), 32'(m_st == 3));
            chk("calc_start", 32'(bus.calc_start), 32'(m_start));
            chk("busy", 32'(bus.busy), 32'(m_st == 5));
            chk("err_code", 32'(bus.err_code), 32'(m_err));
            chk("err_countdown", 32'(bus.err_countdown), 32'(m_st == 6 ? ((m_left - 1) * 10 + ERR - 1) / ERR : 0));
        end
    end
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask
    initial begin
        bus.mode_select = 3'd0; bus.op_select = 3'd0; bus.confirm_btn = 1'b0; bus.back_btn = 1'b0;
        bus.op_legal = 1'b0; bus.sub_done = 1'b0; bus.op_done = 1'b0;
        tick(1);
        chk_en = 1'b1;
        tick(2);
        chk("rst_state", 32'(bus.state_out), 0);
        chk("rst_start", 32'(bus.calc_start), 0);
        chk("rst_cd", 32'(bus.err_countdown), 0);
        rst_n = 1'b1;
        // held confirm enters INPUT exactly once
        bus.confirm_btn = 1'b1; tick();
        chk("in_state", 32'(bus.state_out), 1);
        chk("in_en", 32'(bus.input_en), 1);
        tick(9);
        chk("in_held", 32'(bus.state_out), 1);
        bus.confirm_btn = 1'b0; bus.sub_done = 1'b1; tick();
        bus.sub_done = 1'b0;
        chk("in_done", 32'(bus.state_out), 0);
        chk("in_en_off", 32'(bus.input_en), 0);
        // out-of-state done pulses and a reserved mode are ignored
        bus.sub_done = 1'b1; bus.op_done = 1'b1; tick();
        bus.sub_done = 1'b0; bus.op_done = 1'b0;
        bus.mode_select = 3'd5; bus.confirm_btn = 1'b1; tick();
        bus.confirm_btn = 1'b0; tick();
        chk("reserved", 32'(bus.state_out), 0);
        // GEN exits on back, DISPLAY on simultaneous done+back
        bus.mode_select = 3'd1; bus.confirm_btn = 1'b1; tick();
        chk("gen_en", 32'(bus.gen_en), 1);
        bus.confirm_btn = 1'b0; bus.back_btn = 1'b1; tick();
        bus.back_btn = 1'b0;
        chk("gen_back", 32'(bus.state_out), 0);
        bus.mode_select = 3'd2; bus.confirm_btn = 1'b1; tick();
        bus.confirm_btn = 1'b0; tick(2);
        bus.sub_done = 1'b1; bus.back_btn = 1'b1; tick();
        bus.sub_done = 1'b0; bus.back_btn = 1'b0;
        chk("disp_both", 32'(bus.state_out), 0);
        // legal launch, back ignored while running, op_done completes
        bus.mode_select = 3'd3; bus.confirm_btn = 1'b1; tick();
        chk("calc_sel", 32'(bus.state_out), 4);
        bus.confirm_btn = 1'b0; bus.op_select = 3'd2; bus.op_legal = 1'b1; tick();
        bus.confirm_btn = 1'b1; tick();
        chk("launch_start", 32'(bus.calc_start), 1);
        chk("launch_op", 32'(bus.op_type), 2);
        chk("launch_busy", 32'(bus.busy), 1);
        bus.confirm_btn = 1'b0; bus.op_select = 3'd5; tick();
        chk("start_pulse", 32'(bus.calc_start), 0);
        bus.back_btn = 1'b1; tick();
        bus.back_btn = 1'b0;
        chk("run_back", 32'(bus.state_out), 5);
        tick(7);
        chk("run_op_stable", 32'(bus.op_type), 2);
        bus.op_done = 1'b1; tick();
        bus.op_done = 1'b0;
        chk("run_done", 32'(bus.state_out), 0);
        chk("run_done_err", 32'(bus.err_code), 0);
        // illegal op: ERROR for ERR cycles, confirm ignored, back to CALC_SEL
        bus.confirm_btn = 1'b1; tick();
        bus.confirm_btn = 1'b0; bus.op_legal = 1'b0; tick();
        bus.confirm_btn = 1'b1; tick();
        chk("ill_state", 32'(bus.state_out), 6);
        chk("ill_err", 32'(bus.err_code), 1);
        chk("ill_cd", 32'(bus.err_countdown), 9);
        bus.confirm_btn = 1'b0; tick(3);
        bus.confirm_btn = 1'b1; tick();
        bus.confirm_btn = 1'b0;
        chk("ill_conf", 32'(bus.state_out), 6);
        chk("ill_cd_mid", 32'(bus.err_countdown), 5);
        tick(5);
        chk("ill_last", 32'(bus.err_code), 1);
        chk("ill_cd0", 32'(bus.err_countdown), 0);
        tick();
        chk("ill_exit", 32'(bus.state_out), 4);
        chk("ill_exit_err", 32'(bus.err_code), 0);
        // watchdog after TO cycles, then back aborts ERROR
        bus.op_legal = 1'b1; bus.op_select = 3'd3; bus.confirm_btn = 1'b1; tick();
        bus.confirm_btn = 1'b0; tick(15);
        chk("wd_pre", 32'(bus.state_out), 5);
        tick();
        chk("wd_state", 32'(bus.state_out), 6);
        chk("wd_err", 32'(bus.err_code), 2);
        bus.back_btn = 1'b1; tick();
        bus.back_btn = 1'b0;
        chk("wd_back", 32'(bus.state_out), 0);
        chk("wd_back_err", 32'(bus.err_code), 0);
        // op_done on the timeout cycle wins
        bus.confirm_btn = 1'b1; tick();
        bus.confirm_btn = 1'b0; tick();
        bus.confirm_btn = 1'b1; tick();
        bus.confirm_btn = 1'b0; tick(15);
        bus.op_done = 1'b1; tick();
        bus.op_done = 1'b0;
        chk("race_state", 32'(bus.state_out), 0);
        chk("race_err", 32'(bus.err_code), 0);
        // reset mid-run
        bus.confirm_btn = 1'b1; tick();
        bus.confirm_btn = 1'b0; tick();
        bus.confirm_btn = 1'b1; tick();
        bus.confirm_btn = 1'b0; tick(4);
        rst_n = 1'b0; tick();
        rst_n = 1'b1;
        chk("rst_run_state", 32'(bus.state_out), 0);
        chk("rst_run_busy", 32'(bus.busy), 0);
        chk("rst_run_op", 32'(bus.op_type), 0);
        chk("rst_run_start", 32'(bus.calc_start), 0);
        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
